// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB fade/PWM stage: channel indices and the
// per-channel fade FSM state encoding.
package rgb_pkg;

  localparam int unsigned CH_R = 2;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 0;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_e;

endpackage

// File: rtl/rgb_fade_channel.sv
// One LED channel: fade FSM, brightness level register and registered PWM
// comparator. The level moves one step per tick toward the commanded state.
module rgb_fade_channel
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                on_req,
  output logic                pwm,
  output logic                settled
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  fade_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                pwm_q, pwm_d;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= OFF;
      level_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
    end
  end

  // A drop of on_req wins over reaching full scale in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:       if (on_req) state_d = RAMP_UP;
      ON:        if (!on_req) state_d = RAMP_DOWN;
      RAMP_UP: begin
        if (!on_req)             state_d = RAMP_DOWN;
        else if (level_q == MAX) state_d = ON;
      end
      RAMP_DOWN: begin
        if (on_req)              state_d = RAMP_UP;
        else if (level_q == '0)  state_d = OFF;
      end
      default:                   state_d = OFF;
    endcase
  end

  // Step direction comes from the pre-edge state, so a reversal coinciding
  // with a tick still applies the old direction for that one step.
  always_comb begin
    level_d = level_q;
    if (tick) begin
      if (state_q == RAMP_UP && level_q != MAX)
        level_d = level_q + ONE;
      else if (state_q == RAMP_DOWN && level_q != '0)
        level_d = level_q - ONE;
    end
    pwm_d = (level_q == MAX) | (pwm_cnt < level_q);
  end

  always_comb begin
    settled = (state_q == OFF) | (state_q == ON);
    pwm     = pwm_q;
  end

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB LED driver: registers the on/off code, runs the shared fade prescaler
// and PWM counter, and feeds three fading PWM channels.
module rgb_fade_pwm
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [2:0] Light,
  output logic [2:0] Pwm,
  output logic [2:0] Settled
);

  localparam logic [15:0]         PRESC_LAST = 16'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_ONE    = PWM_BITS'(1);

  logic [2:0]          light_q;
  logic [15:0]         presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick;

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + 16'd1;
    pwm_cnt_d = pwm_cnt_q + CNT_ONE;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      light_q   <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      light_q   <= Light;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  rgb_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .tick    (tick),
    .pwm_cnt (pwm_cnt_q),
    .on_req  (light_q[CH_R]),
    .pwm     (Pwm[CH_R]),
    .settled (Settled[CH_R])
  );

  rgb_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .tick    (tick),
    .pwm_cnt (pwm_cnt_q),
    .on_req  (light_q[CH_G]),
    .pwm     (Pwm[CH_G]),
    .settled (Settled[CH_G])
  );

  rgb_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .tick    (tick),
    .pwm_cnt (pwm_cnt_q),
    .on_req  (light_q[CH_B]),
    .pwm     (Pwm[CH_B]),
    .settled (Settled[CH_B])
  );

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Scoreboard bench for rgb_fade_pwm: a goal/level reference model predicts
// Pwm and Settled for every clock; a negedge monitor compares them.
module tb_rgb_fade_pwm;

  localparam int unsigned PB   = 8;
  localparam int unsigned SD   = 4;
  localparam int unsigned MAXV = (1 << PB) - 1;

  typedef struct packed {
    logic [2:0] pwm;
    logic [2:0] settled;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] light;
  logic [2:0] pwm_o;
  logic [2:0] settled_o;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  rgb_fade_pwm #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Light   (light),
    .Pwm     (pwm_o),
    .Settled (settled_o)
  );

  // Reference model: each channel has a goal brightness (0 or MAXV) taken
  // from the one-clock-delayed command, a busy flag while still travelling,
  // and a level that moves one unit toward the goal on every tick.
  initial begin : model
    int unsigned lvl [3];
    int unsigned goal[3];
    bit          busy[3];
    bit          lq  [3];
    int unsigned cyc;
    int unsigned want, nxt, cnt;
    bit          tk;
    exp_t        e;
    for (int c = 0; c < 3; c++) begin
      lvl[c] = 0; goal[c] = 0; busy[c] = 1'b0; lq[c] = 1'b0;
    end
    cyc = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int c = 0; c < 3; c++) begin
          lvl[c] = 0; goal[c] = 0; busy[c] = 1'b0; lq[c] = 1'b0;
        end
        cyc = 0;
        e.pwm = 3'b000;
        e.settled = 3'b111;
      end else begin
        tk  = ((cyc % SD) == SD - 1);
        cnt = cyc % (MAXV + 1);
        for (int c = 0; c < 3; c++) begin
          e.pwm[c] = (lvl[c] == MAXV) || (cnt < lvl[c]);
          want = lq[c] ? MAXV : 0;
          nxt  = lvl[c];
          if (tk && busy[c]) begin
            if (goal[c] > lvl[c]) nxt = lvl[c] + 1;
            else if (goal[c] < lvl[c]) nxt = lvl[c] - 1;
          end
          if (want != goal[c]) begin
            goal[c] = want;
            busy[c] = 1'b1;
          end else if (busy[c] && lvl[c] == goal[c]) begin
            busy[c] = 1'b0;
          end
          lvl[c] = nxt;
          lq[c]  = light[c];
          e.settled[c] = !busy[c];
        end
        cyc++;
      end
      sb_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (pwm_o !== e.pwm) begin
          n_fail++;
          $display("FAIL pwm t=%0t got=%b exp=%b light=%b", $time, pwm_o, e.pwm, light);
        end
        n_checks++;
        if (settled_o !== e.settled) begin
          n_fail++;
          $display("FAIL settled t=%0t got=%b exp=%b light=%b", $time, settled_o, e.settled, light);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    light = 3'b111;
    step(3);
    rst_n = 1'b1;
    light = 3'b100;
    step(MAXV * SD + 80);
    light = 3'b000;
    step(MAXV * SD + 80);
    // Green rises for 100 ticks then reverses mid-ramp.
    light = 3'b010;
    step(100 * SD);
    light = 3'b000;
    step(110 * SD);
    // Blue reset mid-ramp near level 37.
    light = 3'b001;
    step(37 * SD + 3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    light = 3'b000;
    step(10);
    for (int i = 0; i < 160; i++) begin
      light = 3'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
      else step($urandom_range(4, 60));
    end
    light = 3'b111;
    step(MAXV * SD + 80);
    light = 3'b000;
    step(40);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
